// File: rtl/vslc_pkg.sv
// vslc_pkg: shared definitions for the VSLC scan sequencer.
//   - vslc_state_t : scan FSM state encoding
//   - VSLC_*       : default generic widths
//   - wd_terminal  : watchdog terminal-count test (all-ones of a w-bit counter)
package vslc_pkg;

  localparam int unsigned VSLC_N_IN     = 8;
  localparam int unsigned VSLC_N_OUT    = 8;
  localparam int unsigned VSLC_ADDR_W   = 4;
  localparam int unsigned VSLC_PERIOD_W = 8;
  localparam int unsigned VSLC_WD_W     = 6;
  localparam int unsigned VSLC_DEB_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    STROBE,
    ACK,
    COMMIT,
    DWELL
  } vslc_state_t;

  // True when cnt holds the all-ones value of a w-bit counter.
  function automatic logic wd_terminal(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] tc;
    tc = (32'd1 << w) - 32'd1;
    return cnt == tc;
  endfunction

endpackage

// File: rtl/vslc_debounce.sv
// vslc_debounce: single-channel debounce filter.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : synchronised input bit
//   filt       : filtered bit; flips once raw has differed from it for
//                2**DEB_W-1 consecutive cycles; the counter clears whenever
//                raw equals filt
module vslc_debounce #(
  parameter int unsigned DEB_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  // Count value on the last differing cycle before the flip.
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'((1 << DEB_W) - 2);

  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      filt <= raw;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vslc_scan_sequencer.sv
// vslc_scan_sequencer: scan-cycle sequencer for the VSLC logic controller.
// Each scan latches the input image, steps the program address once per
// instruction with a strobe/ack handshake, commits the output image and
// dwells for a programmable period.
//   clk, rst_n     : clock, asynchronous active-low reset
//   run            : scan enable (sampled in IDLE and at end of scan)
//   period         : dwell cycles after each commit (0 = back-to-back)
//   last_addr      : address of the final program step
//   in_raw         : asynchronous field inputs
//   out_next       : output image computed by the core
//   step_done      : core ack for the current step (sampled in ACK only)
//   addr           : current program step
//   addr_strobe    : 1-cycle pulse, execute step at addr
//   in_image       : input image frozen for the current scan
//   out_image      : committed output image
//   scan_cycle_clk : toggles on every commit
//   fault          : sticky watchdog fault, cleared only by rst_n
// Build option: define VSLC_DEBOUNCE_EN to insert a per-channel debounce
// filter behind the input synchroniser.
module vslc_scan_sequencer
  import vslc_pkg::*;
#(
  parameter int unsigned N_IN     = VSLC_N_IN,
  parameter int unsigned N_OUT    = VSLC_N_OUT,
  parameter int unsigned ADDR_W   = VSLC_ADDR_W,
  parameter int unsigned PERIOD_W = VSLC_PERIOD_W,
  parameter int unsigned WD_W     = VSLC_WD_W,
  parameter int unsigned DEB_W    = VSLC_DEB_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic [ADDR_W-1:0]   last_addr,
  input  logic [N_IN-1:0]     in_raw,
  input  logic [N_OUT-1:0]    out_next,
  input  logic                step_done,
  output logic [ADDR_W-1:0]   addr,
  output logic                addr_strobe,
  output logic [N_IN-1:0]     in_image,
  output logic [N_OUT-1:0]    out_image,
  output logic                scan_cycle_clk,
  output logic                fault
);

  vslc_state_t         state_q, state_d;
  logic [N_IN-1:0]     sync1, sync2, filt;
  logic [ADDR_W-1:0]   last_q;
  logic [WD_W-1:0]     wd, wd_inc;
  logic [PERIOD_W-1:0] dwell;
  logic                wd_expire;

  // Input synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
    end
  end

`ifdef VSLC_DEBOUNCE_EN
  for (genvar i = 0; i < N_IN; i++) begin : g_deb
    vslc_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sync2[i]),
      .filt (filt[i])
    );
  end
`else
  assign filt = sync2;
`endif

  assign wd_inc      = wd + 1'b1;
  assign addr_strobe = (state_q == STROBE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    wd_expire = 1'b0;
    unique case (state_q)
      IDLE:   if (run && !fault) state_d = LATCH;
      LATCH:  state_d = STROBE;
      STROBE: state_d = ACK;
      ACK: begin
        if (step_done) begin
          state_d = (addr == last_q) ? COMMIT : STROBE;
        end else if (wd_terminal(32'(wd_inc), WD_W)) begin
          wd_expire = 1'b1;
          state_d   = IDLE;
        end
      end
      COMMIT: begin
        if (period == '0) state_d = run ? LATCH : IDLE;
        else              state_d = DWELL;
      end
      DWELL:  if (dwell <= PERIOD_W'(1)) state_d = run ? LATCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr           <= '0;
      last_q         <= '0;
      wd             <= '0;
      dwell          <= '0;
      in_image       <= '0;
      out_image      <= '0;
      scan_cycle_clk <= 1'b0;
      fault          <= 1'b0;
    end else begin
      unique case (state_q)
        LATCH: begin
          in_image <= filt;
          addr     <= '0;
          last_q   <= last_addr;
        end
        STROBE: wd <= '0;
        ACK: begin
          if (step_done) begin
            // The final step exits to COMMIT, so addr never wraps.
            if (addr != last_q) addr <= addr + 1'b1;
          end else begin
            wd <= wd_inc;
            if (wd_expire) begin
              fault     <= 1'b1;
              out_image <= '0;
            end
          end
        end
        COMMIT: begin
          out_image      <= out_next;
          scan_cycle_clk <= ~scan_cycle_clk;
          dwell          <= period;
        end
        DWELL: dwell <= dwell - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// tb_vslc_scan_sequencer: directed self-checking bench for vslc_scan_sequencer.
// The debounce scenario is compiled only when VSLC_DEBOUNCE_EN is defined.
module tb_vslc_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run, step_done;
  logic [7:0] period;
  logic [3:0] last_addr;
  logic [7:0] in_raw, out_next;
  logic [3:0] addr;
  logic       addr_strobe, scan_cycle_clk, fault;
  logic [7:0] in_image, out_image;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vslc_scan_sequencer #(
    .N_IN(8), .N_OUT(8), .ADDR_W(4), .PERIOD_W(8), .WD_W(6), .DEB_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .period(period), .last_addr(last_addr),
    .in_raw(in_raw), .out_next(out_next), .step_done(step_done), .addr(addr),
    .addr_strobe(addr_strobe), .in_image(in_image), .out_image(out_image),
    .scan_cycle_clk(scan_cycle_clk), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Core model: acks one cycle after each strobe unless stalled at stall_addr.
  logic        ack_en = 1'b0, stall_en = 1'b0, pend = 1'b0;
  logic [3:0]  stall_addr = 4'd1;
  int unsigned strobes = 0;
  logic [3:0]  strobe_log [64];

  always @(negedge clk) begin
    step_done = pend;
    pend      = 1'b0;
    if (rst_n && addr_strobe) begin
      if (strobes < 64) strobe_log[strobes] = addr;
      strobes++;
      pend = ack_en && !(stall_en && addr == stall_addr);
    end
  end

  task automatic wait_commit(input string tag, input int unsigned limit, output int unsigned took);
    logic prev;
    prev = scan_cycle_clk;
    took = 0;
    while (scan_cycle_clk == prev && took < limit) begin
      @(negedge clk);
      took++;
    end
    check({tag, "_seen"}, 32'(scan_cycle_clk != prev), 32'd1);
  endtask

  task automatic wait_strobe(input string tag, input logic [3:0] a, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (!(addr_strobe && addr == a) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(addr_strobe && addr == a), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned took, t0, n;
    step_done = 1'b0;
    rst_n = 1'b0; run = 1'b0; period = 8'd0; last_addr = 4'd3;
    in_raw = 8'hA5; out_next = 8'h3C; ack_en = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_addr",   32'(addr), 32'h0);
    check("rst_strobe", 32'(addr_strobe), 32'h0);
    check("rst_in",     32'(in_image), 32'h0);
    check("rst_out",    32'(out_image), 32'h0);
    check("rst_scc",    32'(scan_cycle_clk), 32'h0);
    check("rst_fault",  32'(fault), 32'h0);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_strobe", 32'(strobes), 32'd0);

    // Scan 1: 4 steps, period 0
    run = 1'b1;
    t0  = cyc;
    wait_strobe("s1_addr2", 4'd2, 20);
    in_raw = 8'h5A;
    wait_strobe("s1_addr3", 4'd3, 20);
    @(negedge clk);                       // ACK
    @(negedge clk);                       // COMMIT, not yet committed
    check("out_before_commit", 32'(out_image), 32'h0);
    @(negedge clk);
    check("out_commit1", 32'(out_image), 32'h3C);
    check("in_hold_a5",  32'(in_image), 32'hA5);
    check("scc_toggle1", 32'(scan_cycle_clk), 32'h1);
    check("first_scan_cycles", cyc - t0, 32'd11);
    check("s1_strobes", 32'(strobes), 32'd4);
    for (int i = 0; i < 4; i++)
      check("s1_strobe_addr", 32'(strobe_log[i]), 32'(i));

    // Scan 2: back-to-back, new input image latched
    wait_commit("c2", 40, took);
    check("scan_len_p0", took, 32'd10);
    check("in_latch_5a", 32'(in_image), 32'h5A);
    check("scc_toggle2", 32'(scan_cycle_clk), 32'h0);

    // period=5 applies to dwell after the next commit
    period = 8'd5; out_next = 8'hC3;
    wait_commit("c3", 40, took);
    check("scan_len_before_dwell", took, 32'd10);
    check("out_commit3", 32'(out_image), 32'hC3);
    out_next = 8'h99;
    wait_commit("c4", 40, took);
    check("scan_len_p5", took, 32'd15);

    // Drop run during step 2: scan completes then stops
    wait_strobe("s5_addr2", 4'd2, 40);
    run = 1'b0;
    out_next = 8'h66;
    wait_commit("c5", 40, took);
    check("out_commit5", 32'(out_image), 32'h66);
    n = strobes;
    repeat (30) @(negedge clk);
    check("stop_no_strobe", 32'(strobes - n), 32'd0);
    check("stop_addr", 32'(addr), 32'd3);

    // Watchdog: one clean scan, then stall at addr 1
    rst_n = 1'b0; run = 1'b0; period = 8'd0; out_next = 8'h3C; stall_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    wait_commit("wd_c1", 40, took);
    check("wd_out_pre", 32'(out_image), 32'h3C);
    stall_en = 1'b1;
    wait_strobe("wd_addr1", 4'd1, 40);
    t0 = cyc;
    n  = 0;
    while (!fault && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wd_fault", 32'(fault), 32'h1);
    check("wd_latency", cyc - t0, 32'd64);
    check("wd_out_zero", 32'(out_image), 32'h0);
    n = strobes;
    repeat (40) @(negedge clk);
    check("wd_no_strobe", 32'(strobes - n), 32'd0);
    check("wd_fault_sticky", 32'(fault), 32'h1);

    rst_n = 1'b0;
    @(negedge clk);
    check("wd_fault_clear", 32'(fault), 32'h0);

    // Reset mid-scan aborts and clears out_image
    rst_n = 1'b1; stall_en = 1'b0;
    @(negedge clk);
    wait_commit("ab_c1", 40, took);
    check("ab_out_pre", 32'(out_image), 32'h3C);
    wait_strobe("ab_addr2", 4'd2, 40);
    rst_n = 1'b0;
    #1;
    check("ab_out_zero", 32'(out_image), 32'h0);
    check("ab_addr_zero", 32'(addr), 32'h0);
    check("ab_strobe_zero", 32'(addr_strobe), 32'h0);

`ifdef VSLC_DEBOUNCE_EN
    run = 1'b0; in_raw = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    in_raw[0] = 1'b1;
    repeat (2) @(negedge clk);
    in_raw[0] = 1'b0;
    repeat (8) @(negedge clk);
    run = 1'b1;
    wait_strobe("deb_g_addr0", 4'd0, 20);
    run = 1'b0;
    wait_commit("deb_g_c", 40, took);
    check("deb_glitch_rejected", 32'(in_image[0]), 32'h0);
    in_raw[0] = 1'b1;
    repeat (8) @(negedge clk);
    run = 1'b1;
    wait_strobe("deb_l_addr0", 4'd0, 20);
    run = 1'b0;
    wait_commit("deb_l_c", 40, took);
    check("deb_level_passed", 32'(in_image[0]), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
